seq_comp_cascade: RTL and testbench

- Multi-cycle magnitude comparator for the ALU compare path (isNotEqual / isLessThan for branches and slt).
- Walks a WIDTH-bit operand pair MSB-first, one 2-bit slice per clock.
- Carries the EQ/GT cascade in registers and applies the same chaining rule as the 2-bit comparator slice.
- Trades latency for area; sits between the operand latch and the branch/ALU result mux.

---
 rtl/seq_comp_cascade.sv | 85 ++++++++
 tb/tb_seq_comp_cascade.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/seq_comp_cascade.sv
// seq_comp_cascade: multi-cycle magnitude comparator, walks operands MSB-first one 2-bit slice per clock
module seq_comp_cascade #(
  parameter int WIDTH = 32,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             isNotEqual,
  output logic             isLessThan,
  output logic             isGreaterThan
);
  localparam int KW = $clog2(WIDTH / 2);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_in, b_in, a_reg, b_reg;
  logic [KW-1:0] k;
  logic [1:0] sa, sb;
  logic idle, eq, gt, eq_base, gt_base, eq_nx, gt_nx, last;
  // flipping the sign bits turns a signed order into an unsigned one
  assign a_in = {A[WIDTH-1] ^ signed_mode, A[WIDTH-2:0]};
  assign b_in = {B[WIDTH-1] ^ signed_mode, B[WIDTH-2:0]};
  // the accepting edge already consumes the MSB slice, so RUN covers the remaining WIDTH/2-1 slices
  always_comb begin
    idle = state == IDLE;
    sa = idle ? a_in[WIDTH-1:WIDTH-2] : a_reg[WIDTH-1:WIDTH-2];
    sb = idle ? b_in[WIDTH-1:WIDTH-2] : b_reg[WIDTH-1:WIDTH-2];
    eq_base = idle ? 1'b1 : eq;
    gt_base = idle ? 1'b0 : gt;
    eq_nx = eq_base & (sa == sb);
    gt_nx = gt_base | (eq_base & (sa > sb));
    last = (state == RUN && k == '0) || (EARLY_EXIT && !eq_nx);
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = start ? (last ? DONE : RUN) : IDLE;
      RUN:  state_nx = last ? DONE : RUN;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    busy = state == RUN;
    done = state == DONE;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_reg <= '0;
      b_reg <= '0;
      k <= '0;
      eq <= 1'b1;
      gt <= 1'b0;
      isNotEqual <= 1'b0;
      isLessThan <= 1'b0;
      isGreaterThan <= 1'b0;
    end else begin
      if (idle && start) begin
        a_reg <= a_in << 2;
        b_reg <= b_in << 2;
        k <= KW'(WIDTH / 2 - 2);
      end else if (state == RUN) begin
        a_reg <= a_reg << 2;
        b_reg <= b_reg << 2;
        k <= k - 1'b1;
      end
      if ((idle && start) || state == RUN) begin
        eq <= eq_nx;
        gt <= gt_nx;
      end
      if (state_nx == DONE && state != DONE) begin
        isNotEqual <= ~eq_nx;
        isGreaterThan <= gt_nx;
        isLessThan <= ~eq_nx & ~gt_nx;
      end
    end
  end
endmodule

// File: tb/tb_seq_comp_cascade.sv
// tb_seq_comp_cascade: scoreboard bench running a full-walk and an early-exit instance side by side
module tb_seq_comp_cascade;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, sm = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic busy0, done0, ne0, lt0, gt0, busy1, done1, ne1, lt1, gt1;
  typedef struct {logic ne, lt, gt; int lat, acc;} exp_t;
  exp_t q0[$], q1[$];
  int cyc = 0, n_chk = 0, n_pass = 0, bc0 = 0, bc1 = 0;

  seq_comp_cascade #(.WIDTH(32), .EARLY_EXIT(1'b0)) dut0 (
    .clock(clk), .reset(rst_n), .start(start), .signed_mode(sm), .A(a), .B(b),
    .busy(busy0), .done(done0), .isNotEqual(ne0), .isLessThan(lt0), .isGreaterThan(gt0));
  seq_comp_cascade #(.WIDTH(32), .EARLY_EXIT(1'b1)) dut1 (
    .clock(clk), .reset(rst_n), .start(start), .signed_mode(sm), .A(a), .B(b),
    .busy(busy1), .done(done1), .isNotEqual(ne1), .isLessThan(lt1), .isGreaterThan(gt1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int ee_lat(logic [31:0] x, logic [31:0] y);
    logic [31:0] d;
    d = x ^ y;
    for (int i = 15; i >= 0; i--)
      if (d[2*i +: 2] != 2'b00) return 16 - i;
    return 16;
  endfunction

  task automatic push(logic [31:0] x, logic [31:0] y, logic s, int acc);
    exp_t e;
    e.ne = x != y;
    e.lt = s ? ($signed(x) < $signed(y)) : (x < y);
    e.gt = s ? ($signed(x) > $signed(y)) : (x > y);
    e.acc = acc;
    e.lat = 16;
    q0.push_back(e);
    e.lat = ee_lat(x, y);
    q1.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (busy0) bc0++;
    if (done0) begin
      if (q0.size() == 0) check("ee0 spurious done", 1, 0);
      else begin
        e = q0.pop_front();
        check("ee0 ne/lt/gt", {ne0, lt0, gt0}, {e.ne, e.lt, e.gt});
        check("ee0 latency", cyc - e.acc + 1, e.lat);
        check("ee0 busy cycles", bc0, e.lat - 1);
      end
      bc0 = 0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (busy1) bc1++;
    if (done1) begin
      if (q1.size() == 0) check("ee1 spurious done", 1, 0);
      else begin
        e = q1.pop_front();
        check("ee1 ne/lt/gt", {ne1, lt1, gt1}, {e.ne, e.lt, e.gt});
        check("ee1 latency", cyc - e.acc + 1, e.lat);
        check("ee1 busy cycles", bc1, e.lat - 1);
      end
      bc1 = 0;
    end
  end

  task automatic do_cmp(logic [31:0] x, logic [31:0] y, logic s);
    @(negedge clk);
    a = x;
    b = y;
    sm = s;
    start = 1'b1;
    push(x, y, s, cyc + 1);
    @(posedge clk);
    #1 start = 1'b0;
    a = $urandom;
    b = $urandom;
    sm = 1'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #2;
      if (q0.size() == 0 && q1.size() == 0) return;
    end
    check("done timeout", q0.size() + q1.size(), 0);
    q0.delete();
    q1.delete();
  endtask

  initial begin
    #2;
    check("reset ee0 outputs", {busy0, done0, ne0, lt0, gt0}, 0);
    check("reset ee1 outputs", {busy1, done1, ne1, lt1, gt1}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_cmp(32'd5, 32'd3, 1'b0);                   wait_idle();
    do_cmp(32'hFFFF_FFFF, 32'd1, 1'b1);           wait_idle();
    do_cmp(32'hFFFF_FFFF, 32'd1, 1'b0);           wait_idle();
    do_cmp(32'h8000_0000, 32'h7FFF_FFFF, 1'b1);   wait_idle();
    do_cmp(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);   wait_idle();
    do_cmp(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);   wait_idle();
    do_cmp(32'h8000_0000, 32'd0, 1'b0);           wait_idle();
    for (int i = 0; i < 6; i++) begin
      logic [31:0] x;
      x = $urandom;
      do_cmp(x, (i % 2) ? x ^ (32'd1 << (i * 5)) : $urandom, 1'(i / 2));
      wait_idle();
    end
    do_cmp(32'd1, 32'd2, 1'b0);                   wait_idle();
    // abort mid-walk: previous results are non-zero, so clearing is visible
    do_cmp(32'd9, 32'd4, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort ee0 outputs", {busy0, done0, ne0, lt0, gt0}, 0);
    check("abort ee1 outputs", {busy1, done1, ne1, lt1, gt1}, 0);
    q0.delete();
    q1.delete();
    bc0 = 0;
    bc1 = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    do_cmp(32'd2, 32'd7, 1'b0);                   wait_idle();
    // a second start during RUN must be ignored
    do_cmp(32'd1, 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    a = 32'd0;
    b = 32'd1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle();
    // start held high: equal operands so both instances accept every 17 cycles
    begin
      int c;
      @(negedge clk);
      a = 32'h1234_5678;
      b = 32'h1234_5678;
      sm = 1'b0;
      start = 1'b1;
      c = cyc + 1;
      for (int i = 0; i < 3; i++) push(32'h1234_5678, 32'h1234_5678, 1'b0, c + 17 * i);
      wait_idle();
      start = 1'b0;
    end
    repeat (20) @(negedge clk);
    check("queues drained", q0.size() + q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
